// File: rtl/hs_job_ctrl_if.sv
// ---------------------------------------------------------------------------
// hs_job_ctrl_if
// Bundles the per-channel job handshake signals of hs_job_ctrl.
//
// Parameters
//   CH   number of channels (one bit per channel on every vector)
//   ECW  width of each per-channel error counter
//
// Signals (direction seen from the controller, i.e. the slave modport)
//   en, go, abort, fault   in   [CH]      per-channel control requests
//   interrupt              in   1         global start blocker
//   rdy, start, req, ack   out  [CH]      handshake status
//   endd, stop, er         out  [CH]      completion / abort / error pulses
//   err_cnt                out  [CH*ECW]  saturating fault counts, ch c at [c*ECW +: ECW]
//   busy                   out  1         some channel is not idle
//
// master: the side that issues jobs (testbench / system).
// slave : the controller.
// ---------------------------------------------------------------------------
interface hs_job_ctrl_if #(
    parameter int CH  = 4,
    parameter int ECW = 4
) ();

    logic [CH-1:0]     en;
    logic [CH-1:0]     go;
    logic [CH-1:0]     abort;
    logic [CH-1:0]     fault;
    logic              interrupt;

    logic [CH-1:0]     rdy;
    logic [CH-1:0]     start;
    logic [CH-1:0]     req;
    logic [CH-1:0]     ack;
    logic [CH-1:0]     endd;
    logic [CH-1:0]     stop;
    logic [CH-1:0]     er;
    logic [CH*ECW-1:0] err_cnt;
    logic              busy;

    modport master (
        output en, go, abort, fault, interrupt,
        input  rdy, start, req, ack, endd, stop, er, err_cnt, busy
    );

    modport slave (
        input  en, go, abort, fault, interrupt,
        output rdy, start, req, ack, endd, stop, er, err_cnt, busy
    );

endinterface

// File: rtl/hs_job_ctrl.sv
// ---------------------------------------------------------------------------
// hs_job_ctrl
// Multi-channel job handshake controller. Every channel runs its own
// IDLE -> READY -> RUN -> DONE sequence: a job is started by go while READY,
// req/start marks the first RUN cycle and ack follows exactly ACK_LAT cycles
// later, after which a one-cycle endd pulse closes the job. abort produces a
// one-cycle stop pulse; a fault while running holds er for ERR_HOLD cycles
// and bumps a saturating per-channel error counter. A global interrupt
// blocks new starts (IDLE->READY and READY->RUN) but never disturbs a
// channel that is already running or finishing.
//
// Parameters
//   CH        number of independent channels (>=1)
//   ACK_LAT   cycles from req to ack (>=1)
//   ERR_HOLD  cycles er stays high per fault (>=1)
//   ECW       width of each per-channel error counter
//   The interface instance must be built with the same CH and ECW.
//
// Ports
//   clk   in   clock, all logic on the rising edge
//   rst   in   synchronous active-low reset
//   bus   slave modport of hs_job_ctrl_if (see that file for signal list)
//
// All outputs are decoded from registered state/counters only, so there is
// no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module hs_job_ctrl #(
    parameter int CH       = 4,
    parameter int ACK_LAT  = 5,
    parameter int ERR_HOLD = 3,
    parameter int ECW      = 4
) (
    input  logic         clk,
    input  logic         rst,
    hs_job_ctrl_if.slave bus
);

    localparam int CW = $clog2(ACK_LAT + 1);
    localparam int HW = $clog2(ERR_HOLD + 1);

    localparam logic [CW-1:0]  CNT_LAST   = CW'(ACK_LAT);
    localparam logic [HW-1:0]  HOLD_FIRST = HW'(1);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(ERR_HOLD);
    localparam logic [ECW-1:0] ERR_MAX    = {ECW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_RUN,
        S_DONE,
        S_STOP,
        S_ERROR
    } state_t;

    state_t         state_q [CH];
    logic [CW-1:0]  cnt_q   [CH];   // RUN cycle index; 0 on the req cycle
    logic [HW-1:0]  hold_q  [CH];   // ERROR cycle index, 1..ERR_HOLD
    logic [ECW-1:0] err_q   [CH];

    function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
        return (v == ERR_MAX) ? v : v + ECW'(1);
    endfunction

    // ---------------------------------------------------------------------
    // Per-channel state machines. Channels share nothing but interrupt and
    // reset, so one loop body describes them all.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (!rst) begin
                state_q[c] <= S_IDLE;
                cnt_q[c]   <= '0;
                hold_q[c]  <= '0;
                err_q[c]   <= '0;
            end else begin
                unique case (state_q[c])
                    S_IDLE: begin
                        if (bus.en[c] && !bus.interrupt) begin
                            state_q[c] <= S_READY;
                        end
                    end
                    S_READY: begin
                        // abort outranks interrupt, which outranks go; en
                        // dropping here deliberately does not leave READY.
                        if (bus.abort[c]) begin
                            state_q[c] <= S_STOP;
                        end else if (bus.interrupt) begin
                            state_q[c] <= S_IDLE;
                        end else if (bus.go[c]) begin
                            state_q[c] <= S_RUN;
                            cnt_q[c]   <= '0;
                        end
                    end
                    S_RUN: begin
                        // fault beats completion even on the ack cycle, so a
                        // faulted job never produces endd.
                        if (bus.abort[c]) begin
                            state_q[c] <= S_STOP;
                        end else if (bus.fault[c]) begin
                            state_q[c] <= S_ERROR;
                            hold_q[c]  <= HOLD_FIRST;
                            err_q[c]   <= sat_inc(err_q[c]);
                        end else if (cnt_q[c] == CNT_LAST) begin
                            state_q[c] <= S_DONE;
                        end else begin
                            cnt_q[c] <= cnt_q[c] + CW'(1);
                        end
                    end
                    S_DONE, S_STOP: begin
                        state_q[c] <= S_IDLE;
                    end
                    S_ERROR: begin
                        if (hold_q[c] == HOLD_LAST) begin
                            state_q[c] <= S_IDLE;
                        end else begin
                            hold_q[c] <= hold_q[c] + HW'(1);
                        end
                    end
                    default: begin
                        state_q[c] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Moore output decode
    // ---------------------------------------------------------------------
    logic [CH-1:0]     rdy_d;
    logic [CH-1:0]     start_d;
    logic [CH-1:0]     ack_d;
    logic [CH-1:0]     endd_d;
    logic [CH-1:0]     stop_d;
    logic [CH-1:0]     er_d;
    logic [CH*ECW-1:0] err_cnt_d;
    logic              busy_d;

    always_comb begin
        rdy_d     = '0;
        start_d   = '0;
        ack_d     = '0;
        endd_d    = '0;
        stop_d    = '0;
        er_d      = '0;
        err_cnt_d = '0;
        busy_d    = 1'b0;
        for (int c = 0; c < CH; c++) begin
            rdy_d[c]                 = (state_q[c] == S_READY);
            start_d[c]               = (state_q[c] == S_RUN) && (cnt_q[c] == '0);
            ack_d[c]                 = (state_q[c] == S_RUN) && (cnt_q[c] == CNT_LAST);
            endd_d[c]                = (state_q[c] == S_DONE);
            stop_d[c]                = (state_q[c] == S_STOP);
            er_d[c]                  = (state_q[c] == S_ERROR);
            err_cnt_d[c*ECW +: ECW]  = err_q[c];
            busy_d                   = busy_d | (state_q[c] != S_IDLE);
        end
    end

    assign bus.rdy     = rdy_d;
    assign bus.start   = start_d;
    assign bus.req     = start_d;
    assign bus.ack     = ack_d;
    assign bus.endd    = endd_d;
    assign bus.stop    = stop_d;
    assign bus.er      = er_d;
    assign bus.err_cnt = err_cnt_d;
    assign bus.busy    = busy_d;

endmodule
